tage_t0_updater: RTL

TAGE_T0_UPDATER -- requirements
Module: tage_t0_updater

---
 rtl/tage_t0_updater_if.sv | 25 ++
 rtl/tage_t0_updater.sv | 65 ++++++
 2 files changed

// File: rtl/tage_t0_updater_if.sv
// tage_t0_updater_if: update handshake and T0 RAM port bundle for the T0 updater
interface tage_t0_updater_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int CTR_WIDTH  = 2
);
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_idx;
    logic                  upd_taken;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [CTR_WIDTH-1:0]  ram_q;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [CTR_WIDTH-1:0]  ram_wdata;
    logic                  init_done;
    logic [31:0]           upd_count;
    modport master (
        output upd_valid, upd_idx, upd_taken, ram_q,
        input  upd_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, init_done, upd_count
    );
    modport slave (
        input  upd_valid, upd_idx, upd_taken, ram_q,
        output upd_ready, ram_raddr, ram_we, ram_waddr, ram_wdata, init_done, upd_count
    );
endinterface

// File: rtl/tage_t0_updater.sv
// tage_t0_updater: init sweep plus serialized read-modify-write of T0 saturating counters
module tage_t0_updater #(
    parameter int NUM_ENTRIES = 512,
    parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
    parameter int CTR_WIDTH   = 2,
    parameter int INIT_VALUE  = 1
) (
    input logic              clk,
    input logic              rst,
    tage_t0_updater_if.slave bus
);
    typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [CTR_WIDTH-1:0]  CMAX = '1;
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  taken_q;
    logic                  init_done_q;
    logic [31:0]           cnt;
    logic [CTR_WIDTH-1:0]  nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            ptr         <= '0;
            init_done_q <= 1'b0;
            cnt         <= '0;
            idx_q       <= '0;
            taken_q     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state       <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                IDLE: if (bus.upd_valid) begin
                    idx_q   <= bus.upd_idx;
                    taken_q <= bus.upd_taken;
                    state   <= READ;
                end
                READ: state <= WRITE;
                WRITE: begin
                    cnt   <= cnt + 32'd1;
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
    always_comb begin
        nxt = taken_q ? (bus.ram_q == CMAX ? CMAX : bus.ram_q + 1'b1)
                      : (bus.ram_q == '0 ? '0 : bus.ram_q - 1'b1);
    end
    // rst gates every combinational output so nothing leaks to the RAM during an abort
    assign bus.upd_ready = !rst && state == IDLE;
    assign bus.ram_we    = !rst && (state == INIT || state == WRITE);
    assign bus.ram_raddr = (rst || state == INIT) ? '0 : idx_q;
    assign bus.ram_waddr = rst ? '0 : state == INIT ? ptr : idx_q;
    assign bus.ram_wdata = rst ? '0 : state == INIT ? CTR_WIDTH'(INIT_VALUE) : state == WRITE ? nxt : '0;
    assign bus.init_done = init_done_q;
    assign bus.upd_count = cnt;
endmodule
